mac_lane_array: RTL and testbench



---
 rtl/mac_lane_array_if.sv | 32 +++
 rtl/mac_lane_array.sv | 206 ++++++++++++++++++++
 tb/tb_mac_lane_array.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_lane_array_if.sv
// Stream bundle for mac_lane_array: window config, beat input channel, result output channel.
// master = upstream streamer / downstream consumer side, slave = the MAC array itself.
interface mac_lane_array_if #(
    parameter int LANES     = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int KLEN_MAX  = 256,
    parameter int LEN_W     = $clog2(KLEN_MAX + 1)
);
    logic [LEN_W-1:0]              kernel_len;
    logic signed [ACC_WIDTH-1:0]   bias;
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*IN_WIDTH-1:0]     in_data;
    logic [LANES*IN_WIDTH-1:0]     in_weight;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [OUT_WIDTH-1:0]   out_data;
    logic                          out_sat;
    logic                          busy;

    modport master (
        output kernel_len, bias, in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  kernel_len, bias, in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/mac_lane_array.sv
// LANES-wide signed MAC reducing one kernel window into a biased, shifted, saturated result.
// Optional `define MAC_RELU_EN clamps negative results to zero after output saturation.
module mac_lane_array #(
    parameter int LANES     = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 0,
    parameter int KLEN_MAX  = 256,
    parameter int LEN_W     = $clog2(KLEN_MAX + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    mac_lane_array_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        OUT
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;
    localparam logic [LEN_W-1:0]            LEN_MAX = LEN_W'(KLEN_MAX);
    localparam logic [LEN_W-1:0]            LEN_ONE = LEN_W'(1);

    state_t state, state_next;

    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   bias_q;
    logic [LEN_W-1:0]              remaining;
    logic                          sticky;
    logic signed [OUT_WIDTH-1:0]   out_data_q;
    logic                          out_sat_q;

    logic signed [2*IN_WIDTH-1:0]  prod;
    logic signed [ACC_WIDTH-1:0]   beat_sum;
    logic signed [ACC_WIDTH-1:0]   acc_base;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic                          acc_ovf;
    logic signed [ACC_WIDTH-1:0]   biased;
    logic                          bias_ovf;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [OUT_WIDTH-1:0]   narrowed;
    logic                          out_ovf;
    logic signed [OUT_WIDTH-1:0]   result;
    logic [LEN_W-1:0]              len_eff;
    logic                          accept;

    // Returns {overflow, saturated sum}; overflow when the carry-out disagrees with the sign bit.
    function automatic logic [ACC_WIDTH:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, s[ACC_WIDTH-1:0]};
    endfunction

    assign bus.in_ready  = (state == IDLE) || (state == ACCUM);
    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        prod     = '0;
        beat_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            prod     = $signed(bus.in_data[k*IN_WIDTH +: IN_WIDTH]) *
                       $signed(bus.in_weight[k*IN_WIDTH +: IN_WIDTH]);
            beat_sum = beat_sum + ACC_WIDTH'(prod);
        end
    end

    // The first beat of a window starts from zero rather than the stale accumulator.
    always_comb begin
        acc_base            = (state == IDLE) ? '0 : acc;
        {acc_ovf, acc_sum}  = sat_add(acc_base, beat_sum);
        {bias_ovf, biased}  = sat_add(acc, bias_q);
        shifted             = biased >>> OUT_SHIFT;
    end

    always_comb begin
        narrowed = shifted[OUT_WIDTH-1:0];
        out_ovf  = 1'b0;
        if (shifted > OUT_MAX) begin
            narrowed = OUT_MAX[OUT_WIDTH-1:0];
            out_ovf  = 1'b1;
        end else if (shifted < OUT_MIN) begin
            narrowed = OUT_MIN[OUT_WIDTH-1:0];
            out_ovf  = 1'b1;
        end
`ifdef MAC_RELU_EN
        result = narrowed[OUT_WIDTH-1] ? '0 : narrowed;
`else
        result = narrowed;
`endif
    end

    always_comb begin
        len_eff = bus.kernel_len;
        if (bus.kernel_len == '0) begin
            len_eff = LEN_ONE;
        end else if (bus.kernel_len > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
    end

    always_comb begin
        state_next = state;
        if (clr_i) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state_next = (len_eff == LEN_ONE) ? BIAS : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept && (remaining == LEN_ONE)) begin
                        state_next = BIAS;
                    end
                end
                BIAS: begin
                    state_next = OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc        <= '0;
            bias_q     <= '0;
            remaining  <= '0;
            sticky     <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else if (clr_i) begin
            acc        <= '0;
            remaining  <= '0;
            sticky     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc       <= acc_sum;
                        sticky    <= acc_ovf;
                        bias_q    <= bus.bias;
                        remaining <= len_eff - LEN_ONE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc       <= acc_sum;
                        sticky    <= sticky | acc_ovf;
                        remaining <= remaining - LEN_ONE;
                    end
                end
                BIAS: begin
                    out_data_q <= result;
                    out_sat_q  <= sticky | bias_ovf | out_ovf;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        acc    <= '0;
                        sticky <= 1'b0;
                    end
                end
                default: begin
                    acc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_lane_array.sv
// Scoreboard bench for mac_lane_array: expected results are modelled when a window is driven
// and popped when the DUT presents its result.
module tb_mac_lane_array;

    localparam int LANES     = 4;
    localparam int IN_WIDTH  = 8;
    localparam int ACC_WIDTH = 32;
    localparam int OUT_WIDTH = 16;
    localparam int OUT_SHIFT = 0;
    localparam int KLEN_MAX  = 256;
    localparam int LEN_W     = $clog2(KLEN_MAX + 1);
    localparam int BW        = LANES * IN_WIDTH;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 sat;
    } exp_t;

    logic clk;
    logic rst;
    logic clr;
    int   checks;
    int   failures;

    exp_t          exp_q[$];
    logic [BW-1:0] beat_d[$];
    logic [BW-1:0] beat_w[$];

    mac_lane_array_if #(
        .LANES(LANES), .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH), .KLEN_MAX(KLEN_MAX), .LEN_W(LEN_W)
    ) bus ();

    mac_lane_array #(
        .LANES(LANES), .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .OUT_SHIFT(OUT_SHIFT), .KLEN_MAX(KLEN_MAX), .LEN_W(LEN_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(clr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] splat(input logic [IN_WIDTH-1:0] v);
        logic [BW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*IN_WIDTH +: IN_WIDTH] = v;
        return r;
    endfunction

    function automatic exp_t model(input int n, input logic signed [ACC_WIDTH-1:0] b);
        longint amax, amin, omax, omin, acc, bs;
        bit st;
        logic [BW-1:0] dv, wv;
        exp_t e;
        amax = (longint'(1) <<< (ACC_WIDTH - 1)) - 1;
        amin = -amax - 1;
        omax = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
        omin = -omax - 1;
        acc  = 0;
        st   = 1'b0;
        for (int i = 0; i < n; i++) begin
            dv = beat_d[i];
            wv = beat_w[i];
            bs = 0;
            for (int k = 0; k < LANES; k++) begin
                bs += longint'($signed(dv[k*IN_WIDTH +: IN_WIDTH])) *
                      longint'($signed(wv[k*IN_WIDTH +: IN_WIDTH]));
            end
            acc += bs;
            if (acc > amax) begin acc = amax; st = 1'b1; end
            if (acc < amin) begin acc = amin; st = 1'b1; end
        end
        acc += longint'(b);
        if (acc > amax) begin acc = amax; st = 1'b1; end
        if (acc < amin) begin acc = amin; st = 1'b1; end
        acc = acc >>> OUT_SHIFT;
        if (acc > omax) begin acc = omax; st = 1'b1; end
        if (acc < omin) begin acc = omin; st = 1'b1; end
`ifdef MAC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        e.data = acc[OUT_WIDTH-1:0];
        e.sat  = st;
        return e;
    endfunction

    // Presents one beat and holds it until accepted (bounded); returns at accept edge + 1.
    task automatic send_beat(input logic [BW-1:0] d, input logic [BW-1:0] w);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_weight = w;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_accept: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_window(input int len_field, input logic signed [ACC_WIDTH-1:0] b,
                                input int n, input bit push);
        if (push) exp_q.push_back(model(n, b));
        bus.kernel_len = LEN_W'(len_field);
        bus.bias       = b;
        for (int i = 0; i < n; i++) send_beat(beat_d[i], beat_w[i]);
    endtask

    task automatic load_const(input int n, input logic [IN_WIDTH-1:0] d, input logic [IN_WIDTH-1:0] w);
        beat_d.delete();
        beat_w.delete();
        for (int i = 0; i < n; i++) begin
            beat_d.push_back(splat(d));
            beat_w.push_back(splat(w));
        end
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %0d required 0", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat: got %b required 0", bus.out_sat); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit ok;
        exp_t e;
        beat_d.delete();
        beat_w.delete();
        beat_d.push_back(splat(8'd3)); beat_w.push_back(splat(8'd3));
        beat_d.push_back(splat(8'd4)); beat_w.push_back(splat(8'd4));
        beat_d.push_back(splat(8'd5)); beat_w.push_back(splat(8'd5));
        drive_window(3, 32'sd10, 3, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b required 0", bus.out_valid); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: out_valid=%b required 1", bus.out_valid); end
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: out_valid=0 required 1"); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e.data) begin failures++; $display("FAIL basic_data: got %0d required %0d", $signed(bus.out_data), $signed(e.data)); end
        checks++; if (bus.out_sat !== e.sat) begin failures++; $display("FAIL basic_sat: got %b required %b", bus.out_sat, e.sat); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL basic_idle: in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy); end
    endtask

    task automatic test_saturate;
        bit ok;
        exp_t e;
        load_const(1, 8'h80, 8'h80);
        drive_window(1, 32'sd0, 1, 1'b1);
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL sat_timeout: out_valid=0 required 1"); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e.data) begin failures++; $display("FAIL sat_data: got %0d required %0d", $signed(bus.out_data), $signed(e.data)); end
        checks++; if (bus.out_sat !== e.sat) begin failures++; $display("FAIL sat_flag: got %b required %b", bus.out_sat, e.sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        bit ok;
        exp_t e;
        logic [OUT_WIDTH-1:0] held;
        bus.out_ready = 1'b0;
        load_const(2, 8'd7, 8'hFE);
        drive_window(2, -32'sd3, 2, 1'b1);
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: out_valid=0 required 1"); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e.data) begin failures++; $display("FAIL bp_data: got %0d required %0d", $signed(bus.out_data), $signed(e.data)); end
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_data !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold: data=%0d valid=%b in_ready=%b busy=%b required %0d/1/0/1",
                         $signed(bus.out_data), bus.out_valid, bus.in_ready, bus.busy, $signed(held));
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL bp_release: valid=%b in_ready=%b busy=%b required 0/1/0", bus.out_valid, bus.in_ready, bus.busy); end
    endtask

    task automatic test_clear;
        bit ok;
        bit rose;
        exp_t e;
        load_const(5, 8'd9, 8'd9);
        drive_window(5, 32'sd1, 2, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL clr_idle: busy=%b in_ready=%b required 0/1", bus.busy, bus.in_ready); end
        clr = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = splat(8'd9);
        bus.in_weight = splat(8'd9);
        @(posedge clk); #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL clr_drop_beat: busy=%b required 0", bus.busy); end
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) rose = 1'b1;
        end
        checks++; if (rose !== 1'b0) begin failures++; $display("FAIL clr_no_output: out_valid rose=%b required 0", rose); end
        @(posedge clk); #1;
        load_const(1, 8'd2, 8'd2);
        drive_window(1, 32'sd0, 1, 1'b1);
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL clr_next_timeout: out_valid=0 required 1"); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e.data) begin failures++; $display("FAIL clr_next_data: got %0d required %0d", $signed(bus.out_data), $signed(e.data)); end
        checks++; if (bus.out_sat !== e.sat) begin failures++; $display("FAIL clr_next_sat: got %b required %b", bus.out_sat, e.sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        bit ok;
        exp_t e;
        load_const(4, 8'd11, 8'd13);
        drive_window(4, 32'sd5, 2, 1'b0);
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL arst_ctrl: valid=%b busy=%b required 0/0", bus.out_valid, bus.busy); end
        checks++; if (bus.out_data !== '0 || bus.out_sat !== 1'b0) begin failures++; $display("FAIL arst_out: data=%0d sat=%b required 0/0", $signed(bus.out_data), bus.out_sat); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        load_const(2, 8'hF6, 8'd6);
        drive_window(2, 32'sd100, 2, 1'b1);
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL arst_next_timeout: out_valid=0 required 1"); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e.data) begin failures++; $display("FAIL arst_next_data: got %0d required %0d", $signed(bus.out_data), $signed(e.data)); end
        @(posedge clk); #1;
    endtask

    task automatic test_negative;
        bit ok;
        exp_t e;
        load_const(1, 8'd1, 8'hF1);
        drive_window(1, 32'sd10, 1, 1'b1);
        wait_out(ok);
        checks++; if (!ok) begin failures++; $display("FAIL neg_timeout: out_valid=0 required 1"); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e.data) begin failures++; $display("FAIL neg_data: got %0d required %0d", $signed(bus.out_data), $signed(e.data)); end
        checks++; if (bus.out_sat !== e.sat) begin failures++; $display("FAIL neg_sat: got %b required %b", bus.out_sat, e.sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        bit ok;
        exp_t e;
        int lens[8];
        int beats;
        logic signed [ACC_WIDTH-1:0] b;
        lens = '{1, 3, 0, 4, 2, 300, 2, 1};
        for (int w = 0; w < 8; w++) begin
            beats = (lens[w] == 0) ? 1 : ((lens[w] > KLEN_MAX) ? KLEN_MAX : lens[w]);
            beat_d.delete();
            beat_w.delete();
            for (int i = 0; i < beats; i++) begin
                beat_d.push_back(BW'($urandom));
                beat_w.push_back(BW'($urandom));
            end
            b = $signed(ACC_WIDTH'($urandom)) >>> 12;
            if (w == 6) b = 32'sh7FFF_FFF0;
            drive_window(lens[w], b, beats, 1'b1);
            wait_out(ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: window %0d out_valid=0 required 1", w); end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (bus.out_data !== e.data) begin failures++; $display("FAIL b2b_data: window %0d got %0d required %0d", w, $signed(bus.out_data), $signed(e.data)); end
            checks++; if (bus.out_sat !== e.sat) begin failures++; $display("FAIL b2b_sat: window %0d got %b required %b", w, bus.out_sat, e.sat); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        clr            = 1'b0;
        bus.kernel_len = '0;
        bus.bias       = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_weight  = '0;
        bus.out_ready  = 1'b1;

        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_negative();
        test_back_to_back();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
